seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider_div_step.sv | 19 +
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state codes and counter sizing.
package seq_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of a counter that must hold 0..bits-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return (bits > 2) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between the control FSM (master) and seq_divider (slave).
interface seq_divider_if #(
  parameter int unsigned BITS = 8
);
  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_err
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, conditionally subtract.
module div_step #(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS-1:0] rem_i,
  input  logic            bit_i,
  input  logic [BITS-1:0] divisor_i,
  output logic [BITS-1:0] rem_o,
  output logic            q_o
);
  logic [BITS:0] p;

  always_comb begin
    p     = {rem_i, bit_i};
    q_o   = !(p < {1'b0, divisor_i});
    // p < 2*divisor, so the true difference fits in BITS and modulo subtraction is exact.
    rem_o = q_o ? (p[BITS-1:0] - divisor_i) : p[BITS-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIV_ZERO_DETECT_EN: zero divisor short-circuits to DONE and raises div_err.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = cnt_width(BITS);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] dvd_q, dvd_d;
  logic [BITS-1:0] dsr_q, dsr_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic [BITS-1:0] quo_q, quo_d;
  logic [BITS-1:0] res_rem_q, res_rem_d;
`ifdef DIV_ZERO_DETECT_EN
  logic            err_q, err_d;
`endif

  logic [BITS-1:0] step_rem;
  logic            step_q;
  logic            accept;

  div_step #(.BITS(BITS)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[BITS-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign accept = bus.start && (state_q != ST_RUN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_rem_d = res_rem_q;
`ifdef DIV_ZERO_DETECT_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_RUN: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        rem_d = step_rem;
        dvd_d = {dvd_q[BITS-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS - 1)) begin
          state_d   = ST_DONE;
          quo_d     = {dvd_q[BITS-2:0], step_q};
          res_rem_d = step_rem;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_RUN;
          dvd_d   = bus.dividend;
          dsr_d   = bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef DIV_ZERO_DETECT_EN
          err_d   = 1'b0;
          if (bus.divisor == '0) begin
            state_d   = ST_DONE;
            quo_d     = '1;
            res_rem_d = bus.dividend;
            err_d     = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_rem_q <= res_rem_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign bus.div_err = err_q;
`else
  assign bus.div_err = 1'b0;
`endif

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = res_rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes model results, negedge monitor pops on done.
module tb_seq_divider;
  localparam int unsigned BITS = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int err;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  seq_divider_if #(.BITS(BITS)) bus ();
  seq_divider #(.BITS(BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    e.a = a; e.b = b; e.acc = acc;
    if (b == 0) begin
      e.q   = (1 << BITS) - 1;
      e.r   = a;
      e.err = DZ ? 1 : 0;
      e.lat = DZ ? 0 : BITS;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.err = 0;
      e.lat = BITS;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on every done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy_done_excl", int'(bus.busy && bus.done), 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("quotient",  int'(bus.quotient),  e.q);
          check("remainder", int'(bus.remainder), e.r);
          check("div_err",   int'(bus.div_err),   e.err);
          check("latency",   cyc - e.acc,         e.lat);
          if (e.b != 0) begin
            check("invariant",  int'(bus.quotient) * e.b + int'(bus.remainder), e.a);
            check("rem_lt_div", int'(int'(bus.remainder) < e.b), 1);
          end
        end
      end
    end
  end

  task automatic issue(input int a, input int b, input bit push, input bit hold);
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got busy=1 expected idle within 100 cycles");
    end
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    if (push) sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_quotient"}, int'(bus.quotient), 0);
    check({tag, "_remainder"}, int'(bus.remainder), 0);
    check({tag, "_div_err"}, int'(bus.div_err), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed values
    issue(100, 7, 1, 0);
    issue(255, 1, 1, 0);
    issue(5, 9, 1, 0);
    issue(0, 3, 1, 0);
    issue(17, 0, 1, 0);
    wait_idle();

    // Start pulsed during RUN cycle 3 must be ignored
    issue(100, 7, 1, 0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Asynchronous reset in RUN cycle 4 discards the operation
    issue(100, 7, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(200, 10, 1, 0);
    wait_idle();

    // Start held through DONE: back-to-back acceptance
    issue(100, 7, 1, 1);
    bus.dividend = 8'd200;
    bus.divisor  = 8'd10;
    sb.push_back(model(200, 10, cyc + BITS + 1));
    repeat (BITS) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", int'(bus.busy), 1);
    wait_idle();

    // Random pairs, biased towards small and zero divisors
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) b = 0;
      else if ($urandom_range(0, 1) == 1) b = int'($urandom_range(1, 15));
      else b = int'($urandom_range(1, 255));
      issue(a, b, 1, 0);
      if ($urandom_range(0, 7) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
